// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;
   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t S_IDLE = 2'd0;
   localparam fetch_state_t S_RUN  = 2'd1;
   localparam fetch_state_t S_HALT = 2'd2;

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return pc >> 2;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Memory, decode and redirect signals between fetch_controller and its neighbours.
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
);

   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_instr;
   logic               if_valid;
   logic               if_ready;
   logic [31:0]        if_pc;
   logic [INSTR_W-1:0] if_instr;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;

   modport master (
      output imem_addr,
      input  imem_instr,
      output if_valid,
      input  if_ready,
      output if_pc,
      output if_instr,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      input  if_valid,
      output if_ready,
      input  if_pc,
      input  if_instr,
      output redirect_valid,
      output redirect_pc
   );

endinterface

// File: rtl/fetch_perf_counters.sv
// Saturating counters for accepted instructions and decode stall cycles.
module fetch_perf_counters (
   input  logic        clock,
   input  logic        reset,
   input  logic        count_fetch,
   input  logic        count_stall,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls
);

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stalls  <= '0;
      end else begin
         if (count_fetch && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
         if (count_stall && (perf_stalls != '1))  perf_stalls  <= perf_stalls + 32'd1;
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer for a synchronous-read instruction memory with valid/ready output.
// Optional build macro FETCH_PERF_EN adds the perf_fetched/perf_stalls counters.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter int          IMEM_DEPTH = 11,
   parameter int          ADDR_W     = 32
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   start,
   fetch_if.master bus,
   output logic   busy,
   output logic   halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls
`endif
);

   localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

   fetch_state_t state, state_nxt;
   logic [31:0]  issue_pc, issue_pc_nxt;
   logic [31:0]  pc_q, pc_nxt;
   logic         valid_q, valid_nxt;
   logic [31:0]  fetch_pc;
   logic [31:0]  redirect_target;

   function automatic logic in_range(input logic [31:0] pc);
      return word_of(pc) < DEPTH_W;
   endfunction

   // Redirect outranks a stall; a stall re-presents the held word so memory output stays put.
   always_comb begin
      state_nxt       = state;
      issue_pc_nxt    = issue_pc;
      pc_nxt          = pc_q;
      valid_nxt       = 1'b0;
      fetch_pc        = issue_pc;
      redirect_target = bus.redirect_pc & ~32'h3;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (bus.redirect_valid) begin
               fetch_pc = redirect_target;
               if (in_range(redirect_target)) begin
                  valid_nxt    = 1'b1;
                  pc_nxt       = redirect_target;
                  issue_pc_nxt = redirect_target + PC_STEP;
               end else begin
                  state_nxt = S_HALT;
               end
            end else if (valid_q && !bus.if_ready) begin
               fetch_pc  = pc_q;
               valid_nxt = 1'b1;
            end else if (in_range(issue_pc)) begin
               valid_nxt    = 1'b1;
               pc_nxt       = issue_pc;
               issue_pc_nxt = issue_pc + PC_STEP;
            end else begin
               state_nxt = S_HALT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         issue_pc <= RESET_PC;
         pc_q     <= '0;
         valid_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         issue_pc <= issue_pc_nxt;
         pc_q     <= pc_nxt;
         valid_q  <= valid_nxt;
      end
   end

   assign bus.imem_addr = ADDR_W'(word_of(fetch_pc));
   assign bus.if_valid  = valid_q;
   assign bus.if_pc     = pc_q;
   assign bus.if_instr  = bus.imem_instr;
   assign busy          = (state == S_RUN);
   assign halted        = (state == S_HALT);

`ifdef FETCH_PERF_EN
   logic count_fetch, count_stall;

   // A word shown during a redirect is squashed, so it does not count as fetched.
   assign count_fetch = (state == S_RUN) && valid_q && bus.if_ready && !bus.redirect_valid;
   assign count_stall = (state == S_RUN) && valid_q && !bus.if_ready;

   fetch_perf_counters u_perf (
      .clock        (clock),
      .reset        (reset),
      .count_fetch  (count_fetch),
      .count_stall  (count_stall),
      .perf_fetched (perf_fetched),
      .perf_stalls  (perf_stalls)
   );
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus randomized traffic
// compared every cycle against a program-stream model of what decode must see.
module tb_fetch_controller;
   import fetch_pkg::*;

   localparam int DEPTH = 11;

   logic clock;
   logic reset;
   logic start;
   logic busy;
   logic halted;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stalls;
`endif

   fetch_if #(.ADDR_W(32)) bus ();

   fetch_controller #(
      .RESET_PC   (32'h0),
      .IMEM_DEPTH (DEPTH),
      .ADDR_W     (32)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .bus    (bus),
      .busy   (busy),
      .halted (halted)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stalls  (perf_stalls)
`endif
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   logic [31:0] mem [16];
   logic [31:0] acc_q [$];

   // Reference model: mode 0 idle, 1 running, 2 halted; next_pc is the next program address owed to decode.
   int          m_mode;
   logic        m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_next;
   logic [31:0] m_fetched;
   logic [31:0] m_stalls;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic bit in_prog(input logic [31:0] pc);
      return (pc / 4) < DEPTH;
   endfunction

   always @(posedge clock) begin
      if (bus.imem_addr < 16) bus.imem_instr <= mem[bus.imem_addr[3:0]];
      else bus.imem_instr <= NOP;
   end

   always @(posedge clock) begin
      if (!reset && busy && bus.if_valid && bus.if_ready && !bus.redirect_valid)
         acc_q.push_back(bus.if_pc);
   end

   always @(posedge clock) begin
      if (reset) begin
         m_mode    <= 0;
         m_valid   <= 1'b0;
         m_pc      <= '0;
         m_next    <= 32'h0;
         m_fetched <= '0;
         m_stalls  <= '0;
      end else if (m_mode == 1) begin
         if (m_valid && bus.if_ready && !bus.redirect_valid && m_fetched != 32'hFFFF_FFFF)
            m_fetched <= m_fetched + 1;
         if (m_valid && !bus.if_ready && m_stalls != 32'hFFFF_FFFF)
            m_stalls <= m_stalls + 1;
         if (bus.redirect_valid) begin
            if (in_prog(bus.redirect_pc & ~32'h3)) begin
               m_valid <= 1'b1;
               m_pc    <= bus.redirect_pc & ~32'h3;
               m_next  <= (bus.redirect_pc & ~32'h3) + 4;
            end else begin
               m_mode  <= 2;
               m_valid <= 1'b0;
            end
         end else if (!(m_valid && !bus.if_ready)) begin
            if (in_prog(m_next)) begin
               m_valid <= 1'b1;
               m_pc    <= m_next;
               m_next  <= m_next + 4;
            end else begin
               m_mode  <= 2;
               m_valid <= 1'b0;
            end
         end
      end else if (m_mode == 0 && start) begin
         m_mode <= 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_output();
      logic [31:0] exp_addr;
      if (m_mode == 1 && bus.redirect_valid)              exp_addr = (bus.redirect_pc & ~32'h3) / 4;
      else if (m_mode == 1 && m_valid && !bus.if_ready)   exp_addr = m_pc / 4;
      else                                                exp_addr = m_next / 4;
      check("if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
      if (m_valid) begin
         check("if_pc", bus.if_pc, m_pc);
         check("if_instr", bus.if_instr, mem[m_pc[5:2]]);
      end
      check("busy", {31'd0, busy}, {31'd0, m_mode == 1});
      check("halted", {31'd0, halted}, {31'd0, m_mode == 2});
      check("imem_addr", bus.imem_addr, exp_addr);
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_stalls", perf_stalls, m_stalls);
`endif
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         #2;
         check_output();
      end
   end

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      start = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.if_ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      acc_q.delete();
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_pc(input logic [31:0] pc);
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.if_valid && bus.if_pc == pc) begin
            ok = 1;
            break;
         end
         @(negedge clock);
      end
      if (!ok) check("wait_pc_timeout", 32'd0, pc);
   endtask

   task automatic wait_halt();
      bit ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (halted) begin
            ok = 1;
            break;
         end
         @(negedge clock);
      end
      if (!ok) check("wait_halt_timeout", 32'd0, 32'd1);
   endtask

   task automatic apply_stimulus();
      reset = ($urandom_range(0, 199) == 0) || (halted && $urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 3) == 0);
      bus.if_ready = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) bus.redirect_pc = $urandom;
      else bus.redirect_pc = (32'($urandom_range(0, 12)) << 2) | 32'($urandom_range(0, 3));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      bus.if_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;

      do_reset();
      chk_en = 1;
      check("reset_if_valid", {31'd0, bus.if_valid}, 32'd0);
      check("reset_if_pc", bus.if_pc, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_halted", {31'd0, halted}, 32'd0);
      check("reset_imem_addr", bus.imem_addr, 32'd0);

      // Straight-line program to the end of memory.
      bus.if_ready = 1'b1;
      do_start();
      wait_halt();
      check("t1_count", acc_q.size(), 32'd11);
      for (int i = 0; i < acc_q.size() && i < 11; i++) check("t1_pc", acc_q[i], 32'(i * 4));
      check("t1_halted", {31'd0, halted}, 32'd1);
      check("t1_valid", {31'd0, bus.if_valid}, 32'd0);

      // Three-cycle decode stall at pc 8.
      do_reset();
      bus.if_ready = 1'b1;
      do_start();
      wait_pc(32'h8);
      bus.if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t2_stall_pc", bus.if_pc, 32'h8);
         check("t2_stall_instr", bus.if_instr, mem[2]);
         if (i < 2) @(negedge clock);
      end
      bus.if_ready = 1'b1;
      @(negedge clock);
      check("t2_after_pc", bus.if_pc, 32'hC);
      check("t2_after_valid", {31'd0, bus.if_valid}, 32'd1);

      // Redirect while pc 4 is being fetched.
      do_reset();
      bus.if_ready = 1'b1;
      do_start();
      wait_pc(32'h0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h14;
      @(negedge clock);
      bus.redirect_valid = 1'b0;
      check("t3_target_pc", bus.if_pc, 32'h14);
      check("t3_target_valid", {31'd0, bus.if_valid}, 32'd1);
      wait_halt();
      check("t3_count", acc_q.size(), 32'd6);
      if (acc_q.size() > 0) check("t3_first", acc_q[0], 32'h14);
      foreach (acc_q[i]) if (acc_q[i] == 32'h4) check("t3_pc4_accepted", acc_q[i], 32'h14);

      // Redirect during a stall with misaligned target, then an out-of-range redirect.
      do_reset();
      bus.if_ready = 1'b1;
      do_start();
      wait_pc(32'h8);
      bus.if_ready = 1'b0;
      @(negedge clock);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h1E;
      @(negedge clock);
      bus.redirect_valid = 1'b0;
      bus.if_ready = 1'b1;
      check("t4_pc", bus.if_pc, 32'h1C);
      check("t4_instr", bus.if_instr, mem[7]);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h40;
      @(negedge clock);
      bus.redirect_valid = 1'b0;
      check("t5_halted", {31'd0, halted}, 32'd1);
      check("t5_valid", {31'd0, bus.if_valid}, 32'd0);
      @(negedge clock);
      check("t5_valid_later", {31'd0, bus.if_valid}, 32'd0);

      // Reset in the middle of a run.
      do_reset();
      bus.if_ready = 1'b1;
      do_start();
      wait_pc(32'h18);
      reset = 1'b1;
      @(negedge clock);
      check("t6_valid", {31'd0, bus.if_valid}, 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_halted", {31'd0, halted}, 32'd0);
      reset = 1'b0;
      do_start();
      @(negedge clock);
      check("t6_refetch_valid", {31'd0, bus.if_valid}, 32'd1);
      check("t6_refetch_pc", bus.if_pc, 32'h0);

      // Randomized traffic, checked every cycle by the compare process.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock);
         #1;
         apply_stimulus();
      end
      @(negedge clock);
      #4;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
